// File: rtl/areg_seq.sv
// -----------------------------------------------------------------------------
// areg_seq
//
// Purpose
//   Sequencer for the N-bit shift register `areg`. It accepts a parallel word on
//   a valid/ready input port, loads that word into `areg`, then shifts `areg`
//   N times. On every shift it samples `areg`'s serial output Q0 and rebuilds
//   the word LSB-first. The rebuilt word is returned on a valid/ready output
//   port, together with a flag that marks a loopback mismatch.
//
// Handshake semantics (both ports)
//   A transfer happens at the rising clock edge where valid and ready are both
//   high. `in_ready` and `out_valid` come from registered state only. Once
//   `out_valid` is raised it stays high, and `out_word`/`err` stay stable, until
//   the transfer happens. The one exception is `abort` (or reset), which drops
//   the pending word.
//
// Ports
//   clock        in   rising-edge clock, shared with areg
//   resetn       in   synchronous active-low reset
//   in_data      in   [N-1:0] word to transmit
//   in_valid     in   in_data valid
//   in_ready     out  high only in IDLE
//   abort        in   synchronous abort: clears areg and returns to IDLE
//   D            out  [N-1:0] parallel load data to areg (always tx_word)
//   C1, C0       out  areg control: 00 Load, 01 Reset, 10 Shift, 11 Hold
//   q0           in   areg Q0
//   out_word     out  [N-1:0] reassembled word
//   out_valid    out  high only in DONE
//   out_ready    in   consumer accepts out_word
//   err          out  out_word differs from the transmitted word
//   busy         out  state is not IDLE
//   dbg_state_o  out  [2:0] current FSM state, for checkers
// -----------------------------------------------------------------------------
module areg_seq #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         abort,
    output logic [N-1:0] D,
    output logic         C1,
    output logic         C0,
    input  logic         q0,
    output logic [N-1:0] out_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err,
    output logic         busy,
    output logic [2:0]   dbg_state_o
);

    // bit_cnt counts up to N inclusive, so it never wraps within a frame.
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_CLR   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  tx_word_q, tx_word_d;
    logic [N-1:0]  cap_q, cap_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]  out_word_q, out_word_d;
    logic          err_q, err_d;

    // q0 enters at the MSB and the capture register moves toward the LSB.
    // After N shifts, bit i holds areg bit i as it was when loaded. Building
    // the shift through an N+1 wide vector keeps it legal when N == 1.
    logic [N:0]    cap_ext;
    logic [N-1:0]  cap_shift;

    assign cap_ext   = {q0, cap_q};
    assign cap_shift = cap_ext[N:1];

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    // abort has priority over both handshakes. A word offered at the abort
    // edge is refused, and a word waiting in DONE is dropped.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_CLR;
        end else begin
            case (state_q)
                S_IDLE:  if (in_valid) state_d = S_LOAD;
                S_LOAD:  state_d = S_SHIFT;
                S_SHIFT: if (bit_cnt_q == LAST_BIT) state_d = S_DONE;
                S_DONE:  if (out_ready) state_d = S_IDLE;
                S_CLR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        C1        = 1'b1;
        C0        = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_LOAD: begin
                C1 = 1'b0;
                C0 = 1'b0;
            end
            S_SHIFT: begin
                C1 = 1'b1;
                C0 = 1'b0;
            end
            S_DONE: begin
                out_valid = 1'b1;
            end
            S_CLR: begin
                C1 = 1'b0;
                C0 = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign D           = tx_word_q;
    assign out_word    = out_word_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

    // ----------------------------------------------------------------- datapath
    always_comb begin
        tx_word_d  = tx_word_q;
        cap_d      = cap_q;
        bit_cnt_d  = bit_cnt_q;
        out_word_d = out_word_q;
        err_d      = err_q;
        if (!abort) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) tx_word_d = in_data;
                end
                S_LOAD: begin
                    cap_d     = '0;
                    bit_cnt_d = '0;
                end
                S_SHIFT: begin
                    // q0 still shows the pre-shift areg bit at this edge.
                    cap_d     = cap_shift;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        out_word_d = cap_shift;
                        err_d      = (cap_shift != tx_word_q);
                    end
                end
                default: begin
                    tx_word_d = tx_word_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            tx_word_q  <= '0;
            cap_q      <= '0;
            bit_cnt_q  <= '0;
            out_word_q <= '0;
            err_q      <= 1'b0;
        end else begin
            tx_word_q  <= tx_word_d;
            cap_q      <= cap_d;
            bit_cnt_q  <= bit_cnt_d;
            out_word_q <= out_word_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_areg_seq.sv
// -----------------------------------------------------------------------------
// tb_areg_seq
//
// Environment for areg_seq: a behavioural areg model closes the loop. An
// optional fault forces Q0 low on the second shift of a frame. The expected
// word is derived directly from the transmitted word and the fault setting.
// -----------------------------------------------------------------------------
module tb_areg_seq;

    localparam int N = 4;

    // ------------------------------------------------------------ clock/reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         resetn;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic [N-1:0] D;
    logic         C1, C0;
    logic         q0;
    logic [N-1:0] out_word;
    logic         out_valid;
    logic         out_ready;
    logic         err;
    logic         busy;
    logic [2:0]   dbg_state;

    areg_seq #(.N(N)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .abort      (abort),
        .D          (D),
        .C1         (C1),
        .C0         (C0),
        .q0         (q0),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------------- areg model
    logic [N-1:0] areg_m = '0;
    int           shift_idx = 0;
    logic         fault_en;

    always @(posedge clock) begin
        case ({C1, C0})
            2'b00: begin areg_m <= D; shift_idx <= 0; end
            2'b01: areg_m <= '0;
            2'b10: begin areg_m <= areg_m >> 1; shift_idx <= shift_idx + 1; end
            default: ;
        endcase
    end

    assign q0 = (fault_en && shift_idx == 1) ? 1'b0 : areg_m[0];

    // ---------------------------------------------------------------- checker
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- scoreboard
    logic [N:0] exp_q[$];   // {err, word}
    int         acc_edge = 0;
    int         prev_acc_edge = 0;
    logic       ov_prev = 1'b0;
    logic [N-1:0] fault_mask = 4'b0010;

    always @(negedge clock) begin
        logic [N-1:0] exp_w;
        logic [N:0]   e;
        if (!resetn || abort) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_w = fault_en ? (in_data & ~fault_mask) : in_data;
                exp_q.push_back({exp_w != in_data, exp_w});
                prev_acc_edge = acc_edge;
                acc_edge      = cyc + 1;
            end
            if (out_valid && !ov_prev) chk("latency", cyc - acc_edge, 5);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", out_word, e[N-1:0]);
                    chk("err", err, e[N]);
                end
            end
        end
        ov_prev = out_valid;
    end

    // ---------------------------------------------------------------- drivers
    // All drivers start and end 1 time unit after a rising edge.
    task automatic send_word(input logic [N-1:0] w);
        bit ok = 0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (in_ready && exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    logic [1:0]   cseq [6];
    logic [N-1:0] w;
    bit           done_ok;

    initial begin
        cseq = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
        resetn = 1'b0; in_data = '0; in_valid = 1'b0; abort = 1'b0;
        out_ready = 1'b1; fault_en = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_C", {C1, C0}, 2'b11);
        chk("rst_D", D, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock); #1;

        // Basic frame with control-code sequence.
        chk("idle_C", {C1, C0}, 2'b11);
        send_word(4'b1011);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("c_seq", {C1, C0}, cseq[i]);
        end
        wait_idle();
        chk("basic_word", out_word, 4'b1011);

        // Q0 forced low on second shift.
        fault_en = 1'b1;
        send_word(4'b1111);
        wait_idle();
        fault_en = 1'b0;
        chk("fault_word", out_word, 4'b1101);
        chk("fault_err", err, 1);

        // Backpressure in DONE.
        out_ready = 1'b0;
        w = 4'(($urandom_range(0, 15)));
        send_word(w);
        done_ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid) begin done_ok = 1; break; end
        end
        if (!done_ok) chk("done_timeout", 0, 1);
        for (int i = 0; i < 6; i++) begin
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_word", out_word, w);
            chk("hold_err", err, 0);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_C", {C1, C0}, 2'b11);
            @(negedge clock);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_idle();

        // Abort in the second SHIFT cycle.
        send_word(4'b0110);
        @(posedge clock);
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        chk("abort_C", {C1, C0}, 2'b01);
        chk("abort_out_valid", out_valid, 0);
        @(negedge clock);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_areg", areg_m, 0);
        @(posedge clock); #1;

        // Reset in the middle of SHIFT.
        send_word(4'(($urandom_range(0, 15))));
        @(posedge clock);
        @(posedge clock); #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("mid_rst_C", {C1, C0}, 2'b11);
        chk("mid_rst_D", D, 0);
        chk("mid_rst_out_word", out_word, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clock); #1;
        send_word(4'b0001);
        wait_idle();
        chk("post_rst_word", out_word, 4'b0001);

        // Back-to-back stream.
        send_word(4'b1000);
        send_word(4'b0101);
        chk("b2b_spacing", acc_edge - prev_acc_edge, N + 3);
        wait_idle();

        // Random frames with random backpressure and faults.
        for (int k = 0; k < 40; k++) begin
            fault_en = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            send_word(4'(($urandom_range(0, 15))));
            done_ok = 0;
            for (int t = 0; t < 40; t++) begin
                if (!busy) begin done_ok = 1; break; end
                out_ready = (t >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clock); #1;
            end
            if (!done_ok) chk("rand_timeout", 0, 1);
            out_ready = 1'b1;
        end
        fault_en = 1'b0;
        wait_idle();
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
